slt_arbiter: RTL and testbench

- Shares one slt_32bit comparator between two requesters: the ALU execute path (port 0) and the branch/compare unit (port 1).
- Each requester uses a req/done handshake.
- Round-robin arbitration picks the requester, latches its operands and registers the 32-bit set-less-than result.
- Supports signed (slt/slti) and unsigned (sltu/sltiu) compares. Unsigned is done by inverting bit 31 of both operands before the signed comparator.

---
 rtl/slt_arbiter_pkg.sv | 20 ++
 rtl/slt_arbiter_slt32.sv | 12 +
 rtl/slt_arbiter.sv | 93 +++++++++
 tb/tb_slt_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/slt_arbiter_pkg.sv
// Shared definitions for the two-port set-less-than arbiter: FSM encoding,
// result constants and the MSB flip used to turn unsigned compares into signed ones.
package slt_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_t;

  localparam logic [31:0] SLT_TRUE  = 32'h00000001;
  localparam logic [31:0] SLT_FALSE = 32'h00000000;
  localparam int unsigned MSB_FLIP  = 31;

  // Inverting the sign bit maps unsigned ordering onto signed ordering.
  function automatic logic [31:0] msb_flip(input logic [31:0] x, input logic uns);
    msb_flip = x;
    msb_flip[MSB_FLIP] = x[MSB_FLIP] ^ uns;
  endfunction

endpackage

// File: rtl/slt_arbiter_slt32.sv
// Combinational 32-bit signed set-less-than: lt = 1 when a < b (two's complement).
module slt_32bit
  import slt_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] lt
);

  assign lt = ($signed(a) < $signed(b)) ? SLT_TRUE : SLT_FALSE;

endmodule

// File: rtl/slt_arbiter.sv
// Round-robin arbiter sharing one slt_32bit between two req/done requesters.
// Handshake: a requester holds req until it sees its one-cycle done pulse;
// req seen during its own done cycle is masked so it is never served twice.
module slt_arbiter
  import slt_arbiter_pkg::*;
#(
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        uns0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic        uns1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        busy
);

  state_t      state;
  state_t      state_next;
  logic        eff_req0;
  logic        eff_req1;
  logic        grant;
  logic        grant_id;
  logic        prio;
  logic        id;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] slt_out;

  assign eff_req0 = req0 & ~done0;
  assign eff_req1 = req1 & ~done1;
  assign grant    = eff_req0 | eff_req1;
  // On contention the pointer decides; otherwise whoever asks wins.
  assign grant_id = (eff_req0 & eff_req1) ? prio : eff_req1;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant) state_next = ST_CMP;
      ST_CMP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_CMP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done0  <= 1'b0;
      done1  <= 1'b0;
      result <= SLT_FALSE;
      prio   <= INIT_PRIO;
      id     <= 1'b0;
      op_a   <= 32'h0;
      op_b   <= 32'h0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (state == ST_IDLE && grant) begin
        id   <= grant_id;
        op_a <= grant_id ? msb_flip(a1, uns1) : msb_flip(a0, uns0);
        op_b <= grant_id ? msb_flip(b1, uns1) : msb_flip(b0, uns0);
      end
      if (state == ST_CMP) begin
        result <= slt_out;
        done0  <= ~id;
        done1  <= id;
        prio   <= ~id;
      end
    end
  end

  slt_32bit u_slt (
    .a  (op_a),
    .b  (op_b),
    .lt (slt_out)
  );

endmodule

// File: tb/tb_slt_arbiter.sv
// Directed bench for slt_arbiter: table of single-port compares, then
// contention, continuous alternation, operand capture and reset-abort sequences.
module tb_slt_arbiter;

  logic        clock;
  logic        reset;
  logic        req0, uns0, req1, uns1;
  logic [31:0] a0, b0, a1, b1;
  logic        done0, done1, busy;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  slt_arbiter #(.INIT_PRIO(1'b0)) dut (
    .clock  (clock),
    .reset  (reset),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .uns0   (uns0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .uns1   (uns1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .busy   (busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic port, input logic [31:0] a, input logic [31:0] b, input logic uns);
    if (port) begin req1 = 1'b1; a1 = a; b1 = b; uns1 = uns; end
    else      begin req0 = 1'b1; a0 = a; b0 = b; uns0 = uns; end
  endtask

  // One isolated compare on one port; called at a negedge with the DUT idle.
  task automatic run_single(input string name, input logic port, input logic [31:0] a,
                            input logic [31:0] b, input logic uns, input logic [31:0] exp);
    drive(port, a, b, uns);
    step();
    check({name, ".busy"}, {31'b0, busy}, 32'd1);
    check({name, ".early_done"}, {30'b0, done1, done0}, 32'd0);
    step();
    check({name, ".done"}, {30'b0, done1, done0}, port ? 32'd2 : 32'd1);
    check({name, ".result"}, result, exp);
    check({name, ".busy_done"}, {31'b0, busy}, 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check({name, ".done_drop"}, {30'b0, done1, done0}, 32'd0);
  endtask

  initial begin
    logic exp_port;
    logic [31:0] exp_r;

    vecs[0] = '{1'b0, 32'h000FFFF0, 32'h000FFFFF, 1'b0, 32'h1};
    vecs[1] = '{1'b1, 32'hFFF00000, 32'h00000000, 1'b0, 32'h1};
    vecs[2] = '{1'b1, 32'hFFF00000, 32'h00000000, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b1, 32'h1};
    vecs[5] = '{1'b1, 32'h80000000, 32'h80000000, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h1};
    vecs[7] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h0};
    vecs[8] = '{1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'h1};

    reset = 1'b1;
    req0 = 1'b0; a0 = 32'h0; b0 = 32'h0; uns0 = 1'b0;
    req1 = 1'b0; a1 = 32'h0; b1 = 32'h0; uns1 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset.done", {30'b0, done1, done0}, 32'd0);
    check("reset.result", result, 32'h0);
    check("reset.busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    step();

    // Single-port table; last entry leaves the pointer at port 0.
    for (int i = 0; i < 9; i++)
      run_single($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].uns, vecs[i].exp);

    // Simultaneous pair, pointer = 0: port 0 then port 1.
    drive(1'b0, 32'h40000000, 32'h3FFFFFFF, 1'b0);
    drive(1'b1, 32'h00000001, 32'h00000002, 1'b0);
    step();
    check("pair1.busy0", {31'b0, busy}, 32'd1);
    step();
    check("pair1.done0", {30'b0, done1, done0}, 32'd1);
    check("pair1.res0", result, 32'h0);
    req0 = 1'b0;
    step();
    check("pair1.busy1", {31'b0, busy}, 32'd1);
    check("pair1.gap", {30'b0, done1, done0}, 32'd0);
    step();
    check("pair1.done1", {30'b0, done1, done0}, 32'd2);
    check("pair1.res1", result, 32'h1);
    req1 = 1'b0;
    step();

    // Lone port 0 service moves the pointer to port 1 for the next pair.
    run_single("solo0", 1'b0, 32'h5, 32'h6, 1'b0, 32'h1);
    drive(1'b0, 32'h40000000, 32'h3FFFFFFF, 1'b0);
    drive(1'b1, 32'h00000001, 32'h00000002, 1'b0);
    step();
    step();
    check("pair2.first", {30'b0, done1, done0}, 32'd2);
    check("pair2.res1", result, 32'h1);
    req1 = 1'b0;
    step();
    step();
    check("pair2.second", {30'b0, done1, done0}, 32'd1);
    check("pair2.res0", result, 32'h0);
    req0 = 1'b0;
    step();

    // Both held high: pointer now 1, so service alternates 1,0,1,0.
    drive(1'b0, 32'h00000003, 32'hFFFFFFFF, 1'b1);
    drive(1'b1, 32'h00000003, 32'hFFFFFFFF, 1'b0);
    exp_port = 1'b1;
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back(exp_port ? 32'h0 : 32'h1);
      exp_port = ~exp_port;
    end
    exp_port = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      if (n % 2 == 0) begin
        check($sformatf("alt%0d.busy", n), {29'b0, busy, done1, done0}, 32'd4);
      end else begin
        check($sformatf("alt%0d.done", n), {30'b0, done1, done0}, exp_port ? 32'd2 : 32'd1);
        exp_r = exp_q.pop_front();
        check($sformatf("alt%0d.result", n), result, exp_r);
        exp_port = ~exp_port;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();

    // Operand change after grant must not reach the result.
    drive(1'b0, 32'h00000002, 32'h00000001, 1'b0);
    step();
    a0 = 32'h00000001;
    step();
    check("capture.done", {30'b0, done1, done0}, 32'd1);
    check("capture.result", result, 32'h0);
    req0 = 1'b0;
    step();
    drive(1'b0, 32'h00000000, 32'h00000001, 1'b0);
    step();
    a0 = 32'h00000002;
    step();
    check("capture2.done", {30'b0, done1, done0}, 32'd1);
    check("capture2.result", result, 32'h1);
    req0 = 1'b0;
    step();

    // Reset in CMP aborts the compare.
    drive(1'b0, 32'h00000000, 32'h00000001, 1'b0);
    step();
    check("abort.busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    req0 = 1'b0;
    step();
    check("abort.done", {30'b0, done1, done0}, 32'd0);
    check("abort.result", result, 32'h0);
    check("abort.busy_after", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    step();
    check("abort.no_late_done", {30'b0, done1, done0}, 32'd0);
    run_single("after_abort", 1'b0, 32'h80000000, 32'h00000001, 1'b0, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
